// File: rtl/con_unit_if.sv
// con_unit_if: condition-unit bus bundle (strobe/code/data in; result, valid, busy, stats out)
interface con_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic [3:0]            cond_sel;
  logic [DATA_WIDTH-1:0] bus_data;
  logic                  con_in;
  logic                  con_abort;
  logic                  stat_clr;
  logic                  con_out;
  logic                  con_valid;
  logic                  busy;
  logic                  bad_cond;
  logic [CNT_WIDTH-1:0]  eval_cnt;
  logic [CNT_WIDTH-1:0]  taken_cnt;
  modport master (
    output cond_sel, bus_data, con_in, con_abort, stat_clr,
    input  con_out, con_valid, busy, bad_cond, eval_cnt, taken_cnt
  );
  modport slave (
    input  cond_sel, bus_data, con_in, con_abort, stat_clr,
    output con_out, con_valid, busy, bad_cond, eval_cnt, taken_cnt
  );
endinterface

// File: rtl/con_unit.sv
// con_unit: branch-condition unit with two-operand compares, valid pulse, error flag and saturating stats
// Ports: clk, clear (sync active-low reset), cu (slave: cond_sel/bus_data/con_in/con_abort/stat_clr in;
//        con_out/con_valid/busy/bad_cond/eval_cnt/taken_cnt out)
module con_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input logic       clk,
  input logic       clear,
  con_unit_if.slave cu
);
  typedef enum logic {IDLE, WAIT_B} state_t;
  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] op_a, lhs, d;
  logic [3:0]            code_q, code;
  logic                  two_op, fire, capture, result, reserved;
  logic                  con_out, con_valid, bad_cond;
  logic [CNT_WIDTH-1:0]  eval_cnt, taken_cnt;
  always_ff @(posedge clk)
    state <= !clear ? IDLE : state_n;
  // In WAIT_B the latched code and operand A drive the compare; the live cond_sel is ignored.
  always_comb begin
    d        = cu.bus_data;
    two_op   = cu.cond_sel[3] & ~(cu.cond_sel[2] & cu.cond_sel[1]);
    code     = (state == WAIT_B) ? code_q : cu.cond_sel;
    lhs      = (state == WAIT_B) ? op_a : d;
    reserved = &code[3:1];
    capture  = (state == IDLE) & cu.con_in & two_op;
    fire     = cu.con_in & ((state == IDLE) ? ~two_op : ~cu.con_abort);
    state_n  = capture ? WAIT_B : ((state == WAIT_B) & (cu.con_in | cu.con_abort)) ? IDLE : state;
    result   = 1'b0;
    case (code)
      4'b0000: result = ~|d;
      4'b0001: result = |d;
      4'b0010: result = ~d[DATA_WIDTH-1];
      4'b0011: result = d[DATA_WIDTH-1];
      4'b0100: result = ~d[DATA_WIDTH-1] & |d;
      4'b0101: result = d[DATA_WIDTH-1] | ~|d;
      4'b0110: result = 1'b1;
      4'b1000: result = lhs == d;
      4'b1001: result = lhs != d;
      4'b1010: result = $signed(lhs) < $signed(d);
      4'b1011: result = $signed(lhs) >= $signed(d);
      4'b1100: result = lhs < d;
      4'b1101: result = lhs >= d;
      default: result = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!clear) begin
      op_a      <= '0;
      code_q    <= '0;
      con_out   <= 1'b0;
      con_valid <= 1'b0;
      bad_cond  <= 1'b0;
      eval_cnt  <= '0;
      taken_cnt <= '0;
    end else begin
      con_valid <= fire;
      if (fire) con_out <= result;
      if (capture) begin
        op_a   <= d;
        code_q <= cu.cond_sel;
      end
      if (cu.stat_clr) begin
        eval_cnt  <= '0;
        taken_cnt <= '0;
        bad_cond  <= 1'b0;
      end else begin
        if (fire & ~&eval_cnt) eval_cnt <= eval_cnt + CNT_WIDTH'(1);
        if (fire & result & ~&taken_cnt) taken_cnt <= taken_cnt + CNT_WIDTH'(1);
        if (fire & reserved) bad_cond <= 1'b1;
      end
    end
  end
  assign cu.con_out   = con_out;
  assign cu.con_valid = con_valid;
  assign cu.busy      = state == WAIT_B;
  assign cu.bad_cond  = bad_cond;
  assign cu.eval_cnt  = eval_cnt;
  assign cu.taken_cnt = taken_cnt;
endmodule

// File: doc/con_unit.md
Name: con_unit

Overview:
- Parametrised branch-condition unit; successor to the single-operand CON flip-flop in the datapath.
- Evaluates an extended branch condition on bus data and registers the result as con_out for the control unit's PC-load decision.
- Adds signed/unsigned two-operand compares: operands arrive as two successive bus strobes, so a small state machine sequences them.
- Adds result-valid pulse, reserved-code error flag and saturating branch statistics counters.

Parameters:
DATA_WIDTH, 32, width of bus_data and of the latched operand A
CNT_WIDTH, 16, width of the eval_cnt and taken_cnt statistics counters

Ports:
clk  input  1  system clock, all state changes on rising edge
clear  input  1  synchronous, active-low reset; sampled on rising edge of clk
cond_sel  input  4  condition code; from IR condition field via control unit
bus_data  input  DATA_WIDTH  datapath bus value to evaluate
con_in  input  1  evaluate/capture strobe; one cycle per operand
con_abort  input  1  abandon a pending two-operand compare
stat_clr  input  1  zero statistics counters and bad_cond
con_out  output  1  registered condition result (branch taken)
con_valid  output  1  one-cycle pulse, high the cycle con_out takes a new result
busy  output  1  high while waiting for operand B
bad_cond  output  1  sticky: a reserved cond_sel was evaluated
eval_cnt  output  CNT_WIDTH  number of completed evaluations, saturating
taken_cnt  output  CNT_WIDTH  number of evaluations with result 1, saturating

Behaviour:
- Reset (clear=0 at a rising edge): con_out=0, con_valid=0, busy=0, bad_cond=0, eval_cnt=0, taken_cnt=0; state=IDLE; operand A and latched code cleared.
- Reset overrides every other input, including mid-compare in WAIT_B.
- Single-operand codes, evaluated on bus_data (D):
  - 0000 zr: D==0
  - 0001 nz: D!=0
  - 0010 pl: D[MSB]==0
  - 0011 mi: D[MSB]==1
  - 0100 gt: signed D>0
  - 0101 le: signed D<=0
  - 0110 always: 1
  - 0111 never: 0
- Two-operand codes (A = first strobe, B = second strobe):
  - 1000 eq: A==B
  - 1001 ne: A!=B
  - 1010 lt: signed A<B
  - 1011 ge: signed A>=B
  - 1100 ltu: unsigned A<B
  - 1101 geu: unsigned A>=B
- Reserved codes 1110 and 1111: result 0 and bad_cond set to 1.
- States are IDLE and WAIT_B.
- IDLE, con_in=1 with a single-operand or reserved code:
  - Result registered into con_out at this edge.
  - con_valid high for the following cycle (latency 1).
  - State remains IDLE.
- IDLE, con_in=1 with a two-operand code:
  - A <= bus_data; cond_sel latched; next state WAIT_B; busy=1.
  - con_out holds its previous value; no con_valid.
- WAIT_B, con_in=1:
  - B = current bus_data; result uses the latched code.
  - cond_sel on this strobe is ignored.
  - con_out updated and con_valid pulses next cycle; state returns to IDLE; busy=0.
- WAIT_B, con_abort=1:
  - Return to IDLE; con_out unchanged; no con_valid; counters unchanged.
  - Abort wins over a simultaneous con_in.
- con_abort in IDLE: ignored. A con_in in the same cycle proceeds normally.
- con_in=0: con_out holds its value indefinitely; con_valid=0.
- Statistics:
  - On each result, eval_cnt +1; taken_cnt +1 when the result is 1.
  - Each counter saturates at all-ones and never wraps.
- stat_clr=1: eval_cnt, taken_cnt and bad_cond go to 0 at the edge.
  - Takes precedence over a simultaneous increment or bad_cond set.
  - Does not affect con_out, state or busy.
- Width rules:
  - Signed compares treat bit DATA_WIDTH-1 as the sign bit (two's complement).
  - Unsigned compares use the full width.

Test Plan:
- Reset then single-op sweep: clear=0 for 2 cycles, all outputs 0. Then con_in with cond_sel=0000, bus=0 -> con_out=1 and con_valid pulse one cycle later. Then 0011, bus=0x80000000 -> 1; 0100, bus=0xFFFFFFFF -> 0; 0111 -> 0; eval_cnt=4, taken_cnt=2.
- Two-operand signed vs unsigned: cond_sel=1010, A=0xFFFFFFFF, B=0x00000001 -> busy=1 between strobes, con_out=1. Same operands with 1100 -> con_out=0; con_valid pulses only after each B strobe.
- Abort: cond_sel=1000, A=5, then con_abort and con_in together with B=5 -> IDLE, busy=0, con_out keeps prior value, no con_valid, eval_cnt unchanged.
- Reset mid-compare: A captured (WAIT_B), clear=0 one cycle -> state IDLE, busy=0, con_out=0. A following con_in with 1001 is treated as a fresh first operand.
- Reserved and stats: cond_sel=1111 -> con_out=0, bad_cond=1 (sticky across later valid evals). stat_clr asserted in the same cycle as a taken eval -> eval_cnt=0, taken_cnt=0, bad_cond=0.
- Saturation: CNT_WIDTH=4, 20 evaluations with cond_sel=0110 -> eval_cnt=taken_cnt=15, no wrap.
